// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and write-back bit indices for pipeline stage registers
package pipe_pkg;

    localparam int WB_W      = 2;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    // bit positions inside the write-back control bundle
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid flag plus payload register with load, drop and clear enables
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic         clear_i,
    input  logic [W-1:0] din_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o
);

    // clear zeroes the payload, drop only invalidates it so the last payload stays visible
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_o <= 1'b0;
            dout_o  <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            dout_o  <= din_i;
        end else if (drop_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with 2-entry skid buffer and flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WB_W    = pipe_pkg::WB_W,
    parameter int ADDR_W  = pipe_pkg::XLEN,
    parameter int DATA_W  = pipe_pkg::XLEN,
    parameter int RD_W    = pipe_pkg::REG_IDX_W,
    parameter bit GATE_WB = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [RD_W-1:0]   rd_o
);

    localparam int PW = WB_W + ADDR_W + DATA_W + RD_W;

    logic          main_valid;
    logic          skid_valid;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [WB_W-1:0] wb_main;

    logic accept;
    logic main_adv;
    logic main_load;
    logic main_drop;
    logic skid_load;
    logic skid_drop;

    assign in_payload = {WB_i, addr_i, data_i, rd_i};

    // ready depends only on the registered skid flag, so no combinational path from out_ready_i
    assign in_ready_o = !skid_valid;
    assign accept     = in_valid_i && in_ready_o;
    assign main_adv   = !main_valid || out_ready_i;

    // main refills from skid first to keep FIFO order; otherwise from the input
    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        main_d    = in_payload;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        if (main_adv) begin
            if (skid_valid) begin
                main_load = 1'b1;
                main_d    = skid_q;
                skid_drop = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_drop = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .clear_i (flush_i),
        .din_i   (main_d),
        .valid_o (main_valid),
        .dout_o  (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .clear_i (flush_i),
        .din_i   (in_payload),
        .valid_o (skid_valid),
        .dout_o  (skid_q)
    );

    assign {wb_main, addr_o, data_o, rd_o} = main_q;
    assign out_valid_o = main_valid;
    assign WB_o        = (GATE_WB && !main_valid) ? '0 : wb_main;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed-vector bench for pipe_stage_skid
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_ng;
    logic [1:0]  wb_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_valid_ng;
    logic        out_ready;
    logic [1:0]  wb_out;
    logic [1:0]  wb_out_ng;
    logic [31:0] addr_out;
    logic [31:0] addr_out_ng;
    logic [31:0] data_out;
    logic [31:0] data_out_ng;
    logic [4:0]  rd_out;
    logic [4:0]  rd_out_ng;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.GATE_WB(1'b1)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .WB_i        (wb_in),
        .addr_i      (addr_in),
        .data_i      (data_in),
        .rd_i        (rd_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .WB_o        (wb_out),
        .addr_o      (addr_out),
        .data_o      (data_out),
        .rd_o        (rd_out)
    );

    pipe_stage_skid #(.GATE_WB(1'b0)) u_dut_ng (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_ng),
        .WB_i        (wb_in),
        .addr_i      (addr_in),
        .data_i      (data_in),
        .rd_i        (rd_in),
        .out_valid_o (out_valid_ng),
        .out_ready_i (out_ready),
        .WB_o        (wb_out_ng),
        .addr_o      (addr_out_ng),
        .data_o      (data_out_ng),
        .rd_o        (rd_out_ng)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] a);
        in_valid = v;
        wb_in    = wb;
        addr_in  = a;
        data_in  = a ^ 32'hFFFF_0000;
        rd_in    = a[4:0];
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h55);

        // 1: reset held two cycles with traffic and flush present
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_wb", wb_out, 0);
            chk("rst_wb_ng", wb_out_ng, 0);
            chk("rst_addr", addr_out, 0);
            chk("rst_data", data_out, 0);
            chk("rst_rd", rd_out, 0);
            chk("rst_ready", in_ready, 1);
        end
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0);
        tick();
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        // 2: full-rate stream, one-cycle latency, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b01, 32'(i));
            tick();
            chk("strm_valid", out_valid, 1);
            chk("strm_addr", addr_out, 64'(i));
            chk("strm_data", data_out, 64'(32'(i) ^ 32'hFFFF_0000));
            chk("strm_rd", rd_out, 64'(i));
            chk("strm_wb", wb_out, 2'b01);
            chk("strm_ready", in_ready, 1);
        end
        drive(1'b0, 2'b10, 32'h0);
        tick();
        chk("strm_end_valid", out_valid, 0);
        chk("strm_end_wb", wb_out, 0);
        chk("strm_end_wb_ng", wb_out_ng, 2'b01);

        // 3: backpressure fills skid, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'hA);
        tick();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_addr", addr_out, 32'hA);
        chk("bp_a_ready", in_ready, 1);
        drive(1'b1, 2'b01, 32'hB);
        tick();
        chk("bp_b_hold", addr_out, 32'hA);
        chk("bp_b_wb", wb_out, 2'b10);
        chk("bp_b_ready", in_ready, 0);
        drive(1'b1, 2'b11, 32'hEE);
        tick();
        chk("bp_stall_addr", addr_out, 32'hA);
        chk("bp_stall_data", data_out, 32'hFFFF_000A);
        chk("bp_stall_ready", in_ready, 0);
        drive(1'b0, 2'b00, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_valid", out_valid, 1);
        chk("bp_drain_addr", addr_out, 32'hB);
        chk("bp_drain_wb", wb_out, 2'b01);
        chk("bp_drain_ready", in_ready, 1);
        tick();
        chk("bp_empty_valid", out_valid, 0);

        // 4: flush with both slots held; concurrent input discarded
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h1A);
        tick();
        drive(1'b1, 2'b11, 32'h1B);
        tick();
        chk("fl_full_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 2'b11, 32'hC);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_wb", wb_out, 0);
        chk("fl_wb_ng", wb_out_ng, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0);
        tick();
        chk("fl_after_valid", out_valid, 0);
        flush = 1'b1;
        drive(1'b1, 2'b11, 32'hD);
        tick();
        chk("fl_acc_valid", out_valid, 0);
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0);
        tick();
        chk("fl_acc_after", out_valid, 0);

        // 5: bubble gating versus raw write-back
        drive(1'b1, 2'b11, 32'h33);
        tick();
        chk("bub_load_wb", wb_out, 2'b11);
        chk("bub_load_wb_ng", wb_out_ng, 2'b11);
        drive(1'b0, 2'b11, 32'h44);
        tick();
        chk("bub_valid", out_valid, 0);
        chk("bub_wb", wb_out, 0);
        chk("bub_wb_ng", wb_out_ng, 2'b11);
        chk("bub_regwrite", wb_out[WB_REGWRITE], 0);

        // 6: reset while skid full, then a single new entry
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h21);
        tick();
        drive(1'b1, 2'b01, 32'h22);
        tick();
        chk("rs_full_ready", in_ready, 0);
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0);
        tick();
        chk("rs_valid", out_valid, 0);
        chk("rs_addr", addr_out, 0);
        chk("rs_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 32'hD);
        tick();
        chk("rs_d_valid", out_valid, 1);
        chk("rs_d_addr", addr_out, 32'hD);
        chk("rs_d_wb", wb_out, 2'b10);
        drive(1'b0, 2'b00, 32'h0);
        tick();
        chk("rs_d_alone", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
